byte_mem_ctrl: RTL and testbench

- Sits between the cache and main memory.
- Converts one byte-, half- or word-sized cache request into a sequence of single-byte accesses on the 8-bit, synchronous main-memory port.
- Little-endian; read bytes are gathered into one 32-bit response.
- One request in flight at a time; the memory port is pipelined, one byte per cycle.

---
 rtl/byte_mem_ctrl_pkg.sv | 18 +
 rtl/byte_mem_ctrl.sv | 102 ++++++++++
 tb/tb_byte_mem_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/byte_mem_ctrl_pkg.sv
// byte_mem_ctrl_pkg: shared encodings and widths for the byte-serial memory controller
package byte_mem_ctrl_pkg;
    localparam int BYTE_SIZE      = 8;
    localparam int DEF_ADDR_WIDTH = 17;
    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ISSUE = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;
    localparam logic [1:0] S_RESP  = 2'b11;
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        return size == SIZE_BYTE ? 2'd0 : size == SIZE_HALF ? 2'd1 : 2'd3;
    endfunction
endpackage

// File: rtl/byte_mem_ctrl.sv
// byte_mem_ctrl: splits byte/half/word cache requests into single-byte memory accesses.
// Define BYTE_MEM_CTRL_ALIGN_CHECK_EN to reject misaligned half/word requests with resp_err.
module byte_mem_ctrl #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = byte_mem_ctrl_pkg::DEF_ADDR_WIDTH,
    parameter int BYTE_SIZE  = byte_mem_ctrl_pkg::BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN-1:0]        req_wdata,
    output logic                  resp_valid,
    output logic [LEN-1:0]        resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic [BYTE_SIZE-1:0]  writen_data,
    output logic [1:0]            mem_vis_signal,
    input  logic [BYTE_SIZE-1:0]  mem_data
);
    import byte_mem_ctrl_pkg::*;

    logic [1:0]     state, size_l, k, cap_k, last_k;
    logic           wr_l, rd_pend, misaligned;
    logic [LEN-1:0] wdata_l, assembly, asm_next;

    assign last_k     = last_idx(size_l);
    assign req_ready  = state == S_IDLE;
    assign resp_valid = state == S_RESP;

`ifdef BYTE_MEM_CTRL_ALIGN_CHECK_EN
    assign misaligned = req_size[1] ? |req_addr[1:0] : req_size[0] & req_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    // read data trails its issue by one cycle, so the lane captured is the previous k
    always_comb begin
        asm_next = assembly;
        if (rd_pend) asm_next[{cap_k, 3'b000} +: BYTE_SIZE] = mem_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            size_l         <= '0;
            k              <= '0;
            cap_k          <= '0;
            wr_l           <= 1'b0;
            rd_pend        <= 1'b0;
            wdata_l        <= '0;
            assembly       <= '0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_vis_signal <= MEM_IDLE;
            mem_vis_addr   <= '0;
            writen_data    <= '0;
        end else begin
            rd_pend  <= state == S_ISSUE && !wr_l;
            cap_k    <= k;
            assembly <= asm_next;
            case (state)
                S_IDLE: if (req_valid) begin
                    size_l   <= req_size;
                    wr_l     <= req_write;
                    wdata_l  <= req_wdata;
                    k        <= '0;
                    assembly <= '0;
                    if (misaligned) begin
                        state      <= S_RESP;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state          <= S_ISSUE;
                        resp_err       <= 1'b0;
                        mem_vis_signal <= req_write ? MEM_WRITE : MEM_READ;
                        mem_vis_addr   <= req_addr;
                        writen_data    <= req_write ? req_wdata[BYTE_SIZE-1:0] : '0;
                    end
                end
                S_ISSUE: if (k == last_k) begin
                    mem_vis_signal <= MEM_IDLE;
                    writen_data    <= '0;
                    state          <= wr_l ? S_RESP : S_DRAIN;
                    if (wr_l) resp_rdata <= '0;
                end else begin
                    k            <= k + 2'd1;
                    mem_vis_addr <= mem_vis_addr + 1'b1;
                    writen_data  <= wr_l ? wdata_l[{k + 2'd1, 3'b000} +: BYTE_SIZE] : '0;
                end
                S_DRAIN: begin
                    resp_rdata <= asm_next;
                    state      <= S_RESP;
                end
                S_RESP: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_mem_ctrl.sv
// tb_byte_mem_ctrl: table-driven check of byte_mem_ctrl against a byte-wide synchronous memory model
module tb_byte_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [16:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [16:0] mem_vis_addr;
    logic [7:0]  writen_data;
    logic [1:0]  mem_vis_signal;
    logic [7:0]  mem_data;

    always #5 clk = ~clk;

    byte_mem_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_vis_addr(mem_vis_addr), .writen_data(writen_data),
        .mem_vis_signal(mem_vis_signal), .mem_data(mem_data)
    );

    logic [7:0] mem [0:131071];
    logic       loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 131072; i++) mem[i] <= 8'h00;
            mem[17'h00100] <= 8'h11; mem[17'h00101] <= 8'h22;
            mem[17'h00102] <= 8'h33; mem[17'h00103] <= 8'h44;
            mem[17'h00104] <= 8'h55; mem[17'h00105] <= 8'h66;
            mem[17'h00200] <= 8'hA1; mem[17'h00201] <= 8'hA2;
            mem[17'h00202] <= 8'hA3; mem[17'h00203] <= 8'hA4;
            mem[17'h1FFFE] <= 8'h7F; mem[17'h1FFFF] <= 8'h80;
            mem[17'h00000] <= 8'h01; mem[17'h00001] <= 8'h02;
            loaded <= 1'b1;
        end else if (mem_vis_signal == 2'b10) begin
            mem[mem_vis_addr] <= writen_data;
        end
        mem_data <= mem[mem_vis_addr];
    end

    int errors = 0;
    int checks = 0;
    int acc_addr [16];
    logic [7:0] acc_data [16];
    int acc_n;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        exp_err;
        int          exp_n;
    } vec_t;
    vec_t vecs [14];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request from cycle 0, returns the response cycle index (-1 on timeout)
    task automatic do_req(input logic w, input logic [1:0] sz, input logic [16:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output int lat, output logic err);
        logic done;
        req_write = w; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        tick;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = 2'b00;
        acc_n = 0; lat = 1; done = 1'b0;
        while (!done) begin
            if (mem_vis_signal != 2'b00 && acc_n < 16) begin
                acc_addr[acc_n] = int'(mem_vis_addr);
                acc_data[acc_n] = writen_data;
                acc_n++;
            end
            if (resp_valid || lat >= 20) done = 1'b1;
            else begin
                tick;
                lat++;
            end
        end
        rd = resp_rdata; err = resp_err;
        if (!resp_valid) lat = -1;
    endtask

    logic [31:0] rd;
    int          lat;
    logic        err;

    initial begin
        vecs[0]  = '{1'b0, 2'b10, 17'h00100, 32'h0,        32'h44332211, 6, 1'b0, 4};
        vecs[1]  = '{1'b0, 2'b01, 17'h00100, 32'h0,        32'h00002211, 4, 1'b0, 2};
        vecs[2]  = '{1'b0, 2'b00, 17'h00103, 32'h0,        32'h00000044, 3, 1'b0, 1};
        vecs[3]  = '{1'b1, 2'b01, 17'h00200, 32'hDEADBEEF, 32'h0,        3, 1'b0, 2};
        vecs[4]  = '{1'b0, 2'b10, 17'h00200, 32'h0,        32'hA4A3BEEF, 6, 1'b0, 4};
        vecs[5]  = '{1'b0, 2'b00, 17'h1FFFF, 32'h0,        32'h00000080, 3, 1'b0, 1};
        vecs[6]  = '{1'b0, 2'b11, 17'h00100, 32'h0,        32'h44332211, 6, 1'b0, 4};
        vecs[7]  = '{1'b1, 2'b00, 17'h00300, 32'hFFFFFF5A, 32'h0,        2, 1'b0, 1};
        vecs[8]  = '{1'b1, 2'b10, 17'h00304, 32'h12345678, 32'h0,        5, 1'b0, 4};
        vecs[9]  = '{1'b0, 2'b10, 17'h00304, 32'h0,        32'h12345678, 6, 1'b0, 4};
        vecs[10] = '{1'b0, 2'b00, 17'h00300, 32'h0,        32'h0000005A, 3, 1'b0, 1};
`ifdef BYTE_MEM_CTRL_ALIGN_CHECK_EN
        vecs[11] = '{1'b0, 2'b10, 17'h00102, 32'h0,        32'h0,        1, 1'b1, 0};
`else
        vecs[11] = '{1'b0, 2'b10, 17'h00102, 32'h0,        32'h66554433, 6, 1'b0, 4};
`endif
        vecs[12] = '{1'b1, 2'b11, 17'h00308, 32'hAABBCCDD, 32'h0,        5, 1'b0, 4};
        vecs[13] = '{1'b0, 2'b01, 17'h0030A, 32'h0,        32'h0000AABB, 4, 1'b0, 2};

        tick; tick; tick;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_sig", {30'd0, mem_vis_signal}, 32'd0);
        chk("rst_mem_addr", {15'd0, mem_vis_addr}, 32'd0);
        chk("rst_wdata", {24'd0, writen_data}, 32'd0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].addr, vecs[i].wdata, rd, lat, err);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_accesses", i), acc_n, vecs[i].exp_n);
            if (vecs[i].exp_n > 0) chk($sformatf("v%0d_first_addr", i), acc_addr[0], {15'd0, vecs[i].addr});
            if (vecs[i].w && vecs[i].exp_n > 0) chk($sformatf("v%0d_first_wbyte", i), {24'd0, acc_data[0]}, {24'd0, vecs[i].wdata[7:0]});
            tick;
            chk($sformatf("v%0d_ready_after", i), {31'd0, req_ready}, 32'd1);
        end

`ifndef BYTE_MEM_CTRL_ALIGN_CHECK_EN
        do_req(1'b0, 2'b10, 17'h1FFFE, 32'h0, rd, lat, err);
        chk("wrap_rdata", rd, 32'h0201807F);
        chk("wrap_n", acc_n, 4);
        chk("wrap_a0", acc_addr[0], 32'h1FFFE);
        chk("wrap_a1", acc_addr[1], 32'h1FFFF);
        chk("wrap_a2", acc_addr[2], 32'h00000);
        chk("wrap_a3", acc_addr[3], 32'h00001);
`else
        do_req(1'b0, 2'b01, 17'h00101, 32'h0, rd, lat, err);
        chk("half_misalign_err", {31'd0, err}, 32'd1);
        chk("half_misalign_lat", lat, 1);
        chk("half_misalign_n", acc_n, 0);
        chk("half_misalign_rdata", rd, 32'd0);
`endif
        tick;

        req_write = 1'b0; req_size = 2'b10; req_addr = 17'h00100; req_valid = 1'b1;
        tick;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("b2b_ready_c%0d", c), {31'd0, req_ready}, 32'd0);
            if (c < 6) tick;
        end
        chk("b2b_resp1_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b_resp1_rdata", resp_rdata, 32'h44332211);
        req_size = 2'b00; req_addr = 17'h00103;
        tick;
        chk("b2b_ready_again", {31'd0, req_ready}, 32'd1);
        chk("b2b_port_idle", {30'd0, mem_vis_signal}, 32'd0);
        tick;
        req_valid = 1'b0;
        chk("b2b_2nd_sig", {30'd0, mem_vis_signal}, 32'd1);
        chk("b2b_2nd_addr", {15'd0, mem_vis_addr}, 32'h103);
        chk("b2b_2nd_ready", {31'd0, req_ready}, 32'd0);
        tick; tick;
        chk("b2b_resp2_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b_resp2_rdata", resp_rdata, 32'h44);
        tick; tick;
        chk("hold_rdata", resp_rdata, 32'h44);
        chk("hold_no_valid", {31'd0, resp_valid}, 32'd0);

        req_write = 1'b1; req_size = 2'b10; req_addr = 17'h00400; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        chk("abort_c1_sig", {30'd0, mem_vis_signal}, 32'd2);
        rst = 1'b0;
        tick;
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        chk("abort_err", {31'd0, resp_err}, 32'd0);
        chk("abort_sig", {30'd0, mem_vis_signal}, 32'd0);
        chk("abort_addr", {15'd0, mem_vis_addr}, 32'd0);
        chk("abort_wdata", {24'd0, writen_data}, 32'd0);
        tick;
        chk("abort_hold_valid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b1;
        tick;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_mem0", {24'd0, mem[17'h400]}, 32'h0D);
        chk("abort_mem1", {24'd0, mem[17'h401]}, 32'h00);
        do_req(1'b0, 2'b10, 17'h00400, 32'h0, rd, lat, err);
        chk("abort_readback", rd, 32'h0000000D);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
